four_bit_exec_sequencer: RTL



---
 rtl/cpu_seq_pkg.sv | 49 ++++
 rtl/seq_decode.sv | 49 ++++
 rtl/four_bit_exec_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the CPU_5 fetch/execute sequencer: states, instruction fields,
// the ALU opcode map it drives, and the control opcodes it executes itself.
package cpu_seq_pkg;

  localparam int INSTR_W = 14;
  localparam int OPC_W   = 6;
  localparam int OPND_W  = 8;
  localparam int OPC_MSB = 13;
  localparam int OPC_LSB = 8;
  localparam int OPND_MSB = 7;
  localparam int OPND_LSB = 0;

  // ALU opcode map, kept identical to the ALU's own encoding
  localparam logic [OPC_W-1:0] OP_AND_A_B = 6'h00;
  localparam logic [OPC_W-1:0] OP_OR_A_B  = 6'h01;
  localparam logic [OPC_W-1:0] OP_XOR_A_B = 6'h02;
  localparam logic [OPC_W-1:0] OP_ADD_A_B = 6'h03;
  localparam logic [OPC_W-1:0] OP_INC_A   = 6'h04;
  localparam logic [OPC_W-1:0] OP_DEC_A   = 6'h05;
  localparam logic [OPC_W-1:0] OP_SHL_A   = 6'h06;
  localparam logic [OPC_W-1:0] OP_SHR_A   = 6'h07;
  localparam logic [OPC_W-1:0] OP_INC_B   = 6'h08;
  localparam logic [OPC_W-1:0] OP_DEC_B   = 6'h09;
  localparam logic [OPC_W-1:0] OP_SHL_B   = 6'h0A;
  localparam logic [OPC_W-1:0] OP_SHR_B   = 6'h0B;

  // Control opcodes live in 0x20.. so they never alias an ALU operation
  localparam logic [OPC_W-1:0] OP_LDA  = 6'h20;
  localparam logic [OPC_W-1:0] OP_LDB  = 6'h21;
  localparam logic [OPC_W-1:0] OP_JMP  = 6'h22;
  localparam logic [OPC_W-1:0] OP_JZ   = 6'h23;
  localparam logic [OPC_W-1:0] OP_JC   = 6'h24;
  localparam logic [OPC_W-1:0] OP_OUTA = 6'h25;
  localparam logic [OPC_W-1:0] OP_HLT  = 6'h26;
  localparam logic [OPC_W-1:0] OP_NOP  = 6'h27;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_JMP  = 2'd1;
  localparam logic [1:0] BR_JZ   = 2'd2;
  localparam logic [1:0] BR_JC   = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXEC     = 2'd1,
    ST_OUT_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decode for the sequencer: ALU op select, destination,
// load/branch/output/halt controls. Unknown opcodes decode to a NOP.
module seq_decode
  import cpu_seq_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output logic             o_alu_en,
  output logic [OPC_W-1:0] o_alu_op,
  output logic             o_dest_b,
  output logic             o_load,
  output logic [1:0]       o_branch,
  output logic             o_out,
  output logic             o_halt
);

  always_comb begin
    o_alu_en = 1'b0;
    o_alu_op = OP_AND_A_B;
    o_dest_b = 1'b0;
    o_load   = 1'b0;
    o_branch = BR_NONE;
    o_out    = 1'b0;
    o_halt   = 1'b0;
    case (i_opcode)
      OP_AND_A_B, OP_OR_A_B, OP_XOR_A_B, OP_ADD_A_B,
      OP_INC_A, OP_DEC_A, OP_SHL_A, OP_SHR_A: begin
        o_alu_en = 1'b1;
        o_alu_op = i_opcode;
      end
      OP_INC_B, OP_DEC_B, OP_SHL_B, OP_SHR_B: begin
        o_alu_en = 1'b1;
        o_alu_op = i_opcode;
        o_dest_b = 1'b1;
      end
      OP_LDA:  o_load = 1'b1;
      OP_LDB: begin
        o_load   = 1'b1;
        o_dest_b = 1'b1;
      end
      OP_JMP:  o_branch = BR_JMP;
      OP_JZ:   o_branch = BR_JZ;
      OP_JC:   o_branch = BR_JC;
      OP_OUTA: o_out = 1'b1;
      OP_HLT:  o_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/four_bit_exec_sequencer.sv
// Two-cycle fetch/execute sequencer feeding the 4-bit ALU; holds PC, A, B and {Z,C}.
// Optional FOUR_BIT_SEQ_SINGLE_STEP_EN adds a `step` strobe that gates leaving FETCH.
module four_bit_exec_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [OPC_W-1:0]   alu_opcode,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  input  logic [3:0]         alu_r,
  input  logic               alu_zf,
  input  logic               alu_cf,
  output logic [3:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               halted
`ifdef FOUR_BIT_SEQ_SINGLE_STEP_EN
  ,
  input  logic               step
`endif
);

  seq_state_t        r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt, w_pc_inc, w_target;
  logic [3:0]        r_a, r_b, w_a_nxt, w_b_nxt;
  logic              r_z, r_c, w_z_nxt, w_c_nxt;
  logic [3:0]        r_out_data, w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              w_fetch_go;
  logic [OPC_W-1:0]  w_opcode, w_alu_op;
  logic [OPND_W-1:0] w_operand;
  logic              w_alu_en, w_dest_b, w_load, w_out, w_halt;
  logic [1:0]        w_branch;

  assign w_opcode  = rom_data[OPC_MSB:OPC_LSB];
  assign w_operand = rom_data[OPND_MSB:OPND_LSB];
  assign w_target  = PC_W'(w_operand);
  assign w_pc_inc  = r_pc + PC_W'(1);

`ifdef FOUR_BIT_SEQ_SINGLE_STEP_EN
  assign w_fetch_go = step;
`else
  assign w_fetch_go = 1'b1;
`endif

  seq_decode u_decode (
    .i_opcode (w_opcode),
    .o_alu_en (w_alu_en),
    .o_alu_op (w_alu_op),
    .o_dest_b (w_dest_b),
    .o_load   (w_load),
    .o_branch (w_branch),
    .o_out    (w_out),
    .o_halt   (w_halt)
  );

  // The ROM address is the PC itself, so the word is already being read during FETCH
  assign rom_addr  = r_pc;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign halted    = (r_state == ST_HALT);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_z_nxt         = r_z;
    w_c_nxt         = r_c;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    alu_opcode      = OP_AND_A_B;
    alu_a           = r_a;
    alu_b           = r_b;
    case (r_state)
      ST_FETCH: if (w_fetch_go) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        w_pc_nxt    = w_pc_inc;
        if (w_alu_en) begin
          alu_opcode = w_alu_op;
          if (w_dest_b) begin
            alu_a   = r_b;
            w_b_nxt = alu_r;
          end else begin
            w_a_nxt = alu_r;
          end
          w_z_nxt = alu_zf;
          w_c_nxt = alu_cf;
        end
        if (w_load) begin
          if (w_dest_b) w_b_nxt = w_operand[3:0];
          else          w_a_nxt = w_operand[3:0];
        end
        case (w_branch)
          BR_JMP:  w_pc_nxt = w_target;
          BR_JZ:   if (r_z) w_pc_nxt = w_target;
          BR_JC:   if (r_c) w_pc_nxt = w_target;
          default: ;
        endcase
        if (w_out) begin
          w_out_data_nxt  = r_a;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_OUT_WAIT;
        end
        if (w_halt) begin
          w_pc_nxt    = r_pc;
          w_state_nxt = ST_HALT;
        end
      end
      ST_OUT_WAIT: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_z         <= w_z_nxt;
      r_c         <= w_c_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule
